mac_accum: RTL and testbench

Accumulator stage placed directly downstream of the registered 8x8 multiplier. It sums a programmed number of 16-bit products into a wider accumulator and presents the block sum on a valid/ready output port. Typical uses are dot-product and FIR-tap summation. The multiplier's product output drives `in_data`, and the multiplier's registered enable, delayed one cycle, drives `in_valid`.

---
 rtl/mac_accum.sv | 103 ++++++++++
 tb/tb_mac_accum.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// Block-length accumulator behind the 8x8 multiplier: sums i_len products into an
// ACC_W-bit sum with valid/ready output. Define MAC_ACCUM_SAT_EN to clamp instead of wrap.
module mac_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_in_valid,
  input  logic [15:0]      i_in_data,
  output logic             o_busy,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_out_data,
  output logic             o_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_ovf;
  logic             r_busy;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;

  // One extra bit so the carry out flags overflow.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W+1-16){1'b0}}, i_in_data};
  assign w_carry   = w_sum[ACC_W];
  assign w_cnt_nxt = r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};

`ifdef MAC_ACCUM_SAT_EN
  // Once clamped, any further nonzero add carries again, so the sum stays pinned.
  assign w_acc_nxt = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && (i_len != '0)) begin
            r_len   <= i_len;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (i_in_valid) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_carry) r_ovf <= 1'b1;
            if (w_cnt_nxt == r_len) begin
              r_out_data  <= w_acc_nxt;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a 24-bit and a 17-bit instance share stimulus and are
// checked against a whole-block sum model (wrap or clamp per MAC_ACCUM_SAT_EN).
module tb_mac_accum;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] in_data = '0;
  logic        busy_a, ov_a, ovf_a, busy_b, ov_b, ovf_b;
  logic [23:0] od_a;
  logic [16:0] od_b;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mac_accum #(.ACC_W(24), .LEN_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_busy(busy_a), .o_out_valid(ov_a), .i_out_ready(out_ready),
    .o_out_data(od_a), .o_ovf(ovf_a));

  mac_accum #(.ACC_W(17), .LEN_W(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_busy(busy_b), .o_out_valid(ov_b), .i_out_ready(out_ready),
    .o_out_data(od_b), .o_ovf(ovf_b));

  // Block result from the true total: overflow iff total exceeds the width.
  function automatic void model(input logic [15:0] p[$], input int w,
                                output logic [31:0] d, output logic o);
    longint unsigned t = 0;
    longint unsigned lim;
    foreach (p[i]) t += p[i];
    lim = 64'd1 << w;
    o = (t >= lim);
`ifdef MAC_ACCUM_SAT_EN
    d = o ? 32'(lim - 1) : 32'(t);
`else
    d = 32'(t % lim);
`endif
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 0; repeat (2) step;
    n_cmp++; if ({busy_a, ov_a, ovf_a, od_a, busy_b, ov_b, ovf_b, od_b} !== '0) begin
      n_err++; $display("FAIL reset_held got a=%b%b%b %h b=%b%b%b %h exp all 0", busy_a, ov_a, ovf_a, od_a, busy_b, ov_b, ovf_b, od_b); end
    rst_n = 1; step;
    n_cmp++; if ({busy_a, ov_a, ovf_a, od_a} !== '0) begin
      n_err++; $display("FAIL reset_release got %b%b%b %h exp all 0", busy_a, ov_a, ovf_a, od_a); end
    start = 1; len = 5; step; start = 0;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_rise got %b exp 1", busy_a); end
    in_valid = 1; in_data = 16'd100; repeat (2) step; in_valid = 0;
    rst_n = 0; #1;
    n_cmp++; if ({busy_a, ov_a, busy_b, ov_b} !== 4'b0) begin
      n_err++; $display("FAIL reset_mid got busy=%b ov=%b exp 0 0", busy_a, ov_a); end
    step; rst_n = 1;
    in_valid = 1; in_data = 16'd7; repeat (5) step; in_valid = 0;
    n_cmp++; if ({busy_a, ov_a} !== 2'b0) begin
      n_err++; $display("FAIL reset_no_output got busy=%b ov=%b exp 0 0", busy_a, ov_a); end
  endtask

  task automatic test_basic;
    len = 4; start = 1; step; start = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 16'(i + 1); step;
      n_cmp++; if (ov_a !== (i == 3)) begin
        n_err++; $display("FAIL basic_latency beat %0d got %b exp %b", i, ov_a, (i == 3)); end
    end
    in_valid = 0;
    n_cmp++; if (od_a !== 24'd10 || ovf_a !== 1'b0 || od_b !== 17'd10 || ovf_b !== 1'b0) begin
      n_err++; $display("FAIL basic_sum got %0d/%b %0d/%b exp 10/0", od_a, ovf_a, od_b, ovf_b); end
    out_ready = 1; step; out_ready = 0;
    n_cmp++; if (ov_a !== 1'b0 || busy_a !== 1'b0 || od_a !== 24'd10) begin
      n_err++; $display("FAIL basic_handshake got ov=%b busy=%b od=%0d exp 0 0 10", ov_a, busy_a, od_a); end
  endtask

  task automatic test_backpressure;
    logic [15:0] p[$];
    logic [31:0] ea, eb;
    logic        oa, ob;
    p = '{16'hFE01, 16'hFE01, 16'hFE01};
    model(p, 24, ea, oa); model(p, 17, eb, ob);
    len = 3; start = 1; step; start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = p[i]; step; in_valid = 0;
      if (i < 2) repeat (2) begin
        step;
        n_cmp++; if (ov_a !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b exp 0", ov_a); end
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (ov_a !== 1'b1 || od_a !== 24'h02FA03 || od_a !== ea[23:0] || ovf_a !== oa) begin
        n_err++; $display("FAIL bp_hold_a cyc %0d got %b %h/%b exp 1 02fa03/%b", k, ov_a, od_a, ovf_a, oa); end
      n_cmp++; if (ov_b !== 1'b1 || od_b !== eb[16:0] || ovf_b !== ob) begin
        n_err++; $display("FAIL bp_hold_b cyc %0d got %b %h/%b exp 1 %h/%b", k, ov_b, od_b, ovf_b, eb[16:0], ob); end
      step;
    end
    out_ready = 1; step; out_ready = 0;
    repeat (3) begin
      n_cmp++; if (ov_a !== 1'b0 || od_a !== 24'h02FA03) begin
        n_err++; $display("FAIL bp_single_handshake got ov=%b od=%h exp 0 02fa03", ov_a, od_a); end
      step;
    end
  endtask

  task automatic test_overflow;
    n_cmp++; if (ovf_b !== 1'b1) begin n_err++; $display("FAIL ovf_sticky_idle got %b exp 1", ovf_b); end
    len = 3; start = 1; step; start = 0;
    n_cmp++; if (ovf_b !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_start got %b exp 0", ovf_b); end
    repeat (3) begin in_valid = 1; in_data = 16'hFE01; step; end
    in_valid = 0;
`ifdef MAC_ACCUM_SAT_EN
    n_cmp++; if (od_b !== 17'h1FFFF || ovf_b !== 1'b1) begin
      n_err++; $display("FAIL ovf_sat got %h/%b exp 1ffff/1", od_b, ovf_b); end
`else
    n_cmp++; if (od_b !== 17'h0FA03 || ovf_b !== 1'b1) begin
      n_err++; $display("FAIL ovf_wrap got %h/%b exp 0fa03/1", od_b, ovf_b); end
`endif
    n_cmp++; if (od_a !== 24'h02FA03 || ovf_a !== 1'b0) begin
      n_err++; $display("FAIL ovf_wide got %h/%b exp 02fa03/0", od_a, ovf_a); end
    out_ready = 1; step; out_ready = 0;
  endtask

  task automatic test_ignored;
    start = 1; len = 0; step; start = 0;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL len0_ignored got busy=%b exp 0", busy_a); end
    len = 2; start = 1; step;
    in_valid = 1; in_data = 16'd5; start = 1; len = 1; step;
    n_cmp++; if (ov_a !== 1'b0) begin n_err++; $display("FAIL start_in_accum got ov=%b exp 0", ov_a); end
    start = 0; in_data = 16'd6; step; in_valid = 0;
    n_cmp++; if (ov_a !== 1'b1 || od_a !== 24'd11) begin
      n_err++; $display("FAIL start_in_accum_sum got %b %0d exp 1 11", ov_a, od_a); end
    out_ready = 1; start = 1; len = 3; step; start = 0; out_ready = 0;
    n_cmp++; if (busy_a !== 1'b0 || ov_a !== 1'b0) begin
      n_err++; $display("FAIL start_in_handshake got busy=%b ov=%b exp 0 0", busy_a, ov_a); end
    in_valid = 1; in_data = 16'hFFFF; repeat (2) step; in_valid = 0;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL idle_valid got busy=%b exp 0", busy_a); end
    start = 1; len = 1; step; start = 0;
    in_valid = 1; in_data = 16'd9; step; in_valid = 0;
    n_cmp++; if (od_a !== 24'd9 || ov_a !== 1'b1) begin
      n_err++; $display("FAIL idle_valid_sum got %0d/%b exp 9/1", od_a, ov_a); end
    out_ready = 1; step; out_ready = 0;
  endtask

  task automatic test_back_to_back;
    len = 2; start = 1; step; start = 0;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b exp 1", busy_a); end
    in_valid = 1; in_data = 16'd3; step; in_data = 16'd4; step; in_valid = 0;
    n_cmp++; if (od_a !== 24'd7 || ov_a !== 1'b1) begin
      n_err++; $display("FAIL b2b_sum got %0d/%b exp 7/1", od_a, ov_a); end
    out_ready = 1; step; out_ready = 0;
  endtask

  task automatic test_random;
    logic [15:0] p[$];
    logic [31:0] ea, eb;
    logic        oa, ob;
    int          n;
    for (int b = 0; b < 25; b++) begin
      p.delete();
      n = $urandom_range(1, 8);
      len = 8'(n); start = 1; step; start = 0;
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 0; in_data = 16'($urandom); start = 1'($urandom); len = 8'($urandom);
          step;
          n_cmp++; if (ov_a !== 1'b0) begin n_err++; $display("FAIL rnd_bubble blk %0d got %b exp 0", b, ov_a); end
        end
        start = 0;
        in_valid = 1; in_data = 16'($urandom); p.push_back(in_data); step;
        n_cmp++; if (ov_a !== (i == n - 1) || ov_b !== (i == n - 1)) begin
          n_err++; $display("FAIL rnd_latency blk %0d beat %0d got %b%b exp %b", b, i, ov_a, ov_b, (i == n - 1)); end
      end
      in_valid = 0;
      model(p, 24, ea, oa); model(p, 17, eb, ob);
      for (int k = $urandom_range(0, 3); k >= 0; k--) begin
        n_cmp++; if (od_a !== ea[23:0] || ovf_a !== oa || ov_a !== 1'b1) begin
          n_err++; $display("FAIL rnd_a blk %0d got %h/%b exp %h/%b", b, od_a, ovf_a, ea[23:0], oa); end
        n_cmp++; if (od_b !== eb[16:0] || ovf_b !== ob || ov_b !== 1'b1) begin
          n_err++; $display("FAIL rnd_b blk %0d got %h/%b exp %h/%b", b, od_b, ovf_b, eb[16:0], ob); end
        if (k > 0) step;
      end
      out_ready = 1; step; out_ready = 0;
      n_cmp++; if (ov_a !== 1'b0 || busy_a !== 1'b0) begin
        n_err++; $display("FAIL rnd_handshake blk %0d got ov=%b busy=%b exp 0 0", b, ov_a, busy_a); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_ignored;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
